// File: rtl/ro_quant_pack_writer.sv
// Requantises 8-lane x 24b partial sums to int8, packs pixel pairs into 128b words and
// issues one DDR write command ahead of each (tile, line, group) row segment.
module ro_quant_pack_writer #(
    parameter int IN_W   = 192,
    parameter int OUT_W  = 128,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_config_valid,
    output logic              s_config_ready,
    input  logic [31:0]       s_config_data,
    input  logic              s_valid,
    input  logic [IN_W-1:0]   s_data,
    output logic              s_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [15:0]       cmd_len,
    output logic              m_valid,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              done,
    output logic [1:0]        status
);

    typedef enum logic [1:0] {
        ST_CONFIG = 2'd0,
        ST_CMD    = 2'd1,
        ST_DATA   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cfg_idx_q;
    logic [11:0]         img_w_q, img_h_q;
    logic [4:0]          shift_q;
    logic                relu_q;
    logic [7:0]          w_tile_q;
    logic [12:0]         groups_q;
    logic [15:0]         row_bytes_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [12:0]         grp_q;
    logic [11:0]         line_q;
    logic [7:0]          tile_q;
    logic [11:0]         pix_q;
    logic                in_done_q;
    logic [63:0]         hold_q;
    logic [OUT_W-1:0]    m_data_q;
    logic                m_valid_q, m_last_q;

    logic                cfg_acc, beat_acc, m_acc, pix_last, last_seg;
    logic [63:0]         q_pix;
    logic [12:0]         half_w;

    function automatic logic [7:0] quant(input logic [23:0] x, input logic [4:0] sh,
                                         input logic relu);
        logic signed [24:0] xs, rnd, y;
        xs  = {x[23], x};
        rnd = (sh == 5'd0) ? '0 : (25'sd1 <<< (sh - 5'd1));
        y   = (xs + rnd) >>> sh;
        if (relu && y < 25'sd0) y = '0;
        if (y > 25'sd127)       return 8'h7F;
        else if (y < -25'sd128) return 8'h80;
        else                    return y[7:0];
    endfunction

    always_comb begin
        q_pix = '0;
        for (int unsigned i = 0; i < 8; i++)
            q_pix[63-8*i -: 8] = quant(s_data[IN_W-1-24*i -: 24], shift_q, relu_q);
    end

    assign cfg_acc  = s_config_valid & s_config_ready;
    assign beat_acc = s_valid & s_ready;
    assign m_acc    = m_valid_q & m_ready;
    assign pix_last = (pix_q == img_w_q - 12'd1);
    assign last_seg = (grp_q == groups_q - 13'd1) && (line_q == img_h_q - 12'd1)
                   && (tile_q == w_tile_q - 8'd1);
    assign half_w   = ({1'b0, s_config_data[11:0]} + 13'd1) >> 1;

    // in_done_q closes the input side once a segment's last pixel is in, so the next
    // segment's beats wait for their own command.
    assign s_ready  = (state_q == ST_DATA) && !in_done_q && (pix_q < img_w_q)
                   && (!m_valid_q || m_ready);
    assign cmd_addr = addr_q;
    assign cmd_len  = row_bytes_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign status   = state_q;

    always_comb begin
        state_d        = state_q;
        s_config_ready = 1'b0;
        cmd_valid      = 1'b0;
        done           = 1'b0;
        unique case (state_q)
            ST_CONFIG: begin
                s_config_ready = 1'b1;
                if (cfg_acc && cfg_idx_q == 2'd2) state_d = ST_CMD;
            end
            ST_CMD: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (m_acc && m_last_q) state_d = last_seg ? ST_DONE : ST_CMD;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_CONFIG;
            end
            default: state_d = ST_CONFIG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_CONFIG;
            cfg_idx_q   <= '0;
            img_w_q     <= '0;
            img_h_q     <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            w_tile_q    <= '0;
            groups_q    <= '0;
            row_bytes_q <= '0;
            addr_q      <= '0;
            grp_q       <= '0;
            line_q      <= '0;
            tile_q      <= '0;
            pix_q       <= '0;
            in_done_q   <= 1'b0;
            hold_q      <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cfg_acc) begin
                cfg_idx_q <= (cfg_idx_q == 2'd2) ? 2'd0 : cfg_idx_q + 2'd1;
                case (cfg_idx_q)
                    2'd0: begin
                        img_w_q     <= s_config_data[11:0];
                        img_h_q     <= s_config_data[23:12];
                        shift_q     <= s_config_data[28:24];
                        relu_q      <= s_config_data[29];
                        row_bytes_q <= {half_w[11:0], 4'b0000};
                    end
                    2'd1: begin
                        w_tile_q <= s_config_data[7:0];
                        groups_q <= s_config_data[23:11];
                    end
                    default: addr_q <= s_config_data[ADDR_W-1:0];
                endcase
            end
            if (beat_acc) begin
                pix_q <= pix_last ? '0 : pix_q + 12'd1;
                if (pix_last) in_done_q <= 1'b1;
                if (!pix_q[0] && !pix_last) hold_q <= q_pix;
            end
            if (beat_acc && (pix_q[0] || pix_last)) begin
                m_valid_q <= 1'b1;
                m_last_q  <= pix_last;
                m_data_q  <= pix_q[0] ? {hold_q, q_pix} : {q_pix, 64'h0};
            end else if (m_acc) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
            if (m_acc && m_last_q) begin
                in_done_q <= 1'b0;
                addr_q    <= addr_q + ADDR_W'(row_bytes_q);
                if (grp_q == groups_q - 13'd1) begin
                    grp_q <= '0;
                    if (line_q == img_h_q - 12'd1) begin
                        line_q <= '0;
                        tile_q <= (tile_q == w_tile_q - 8'd1) ? '0 : tile_q + 8'd1;
                    end else begin
                        line_q <= line_q + 12'd1;
                    end
                end else begin
                    grp_q <= grp_q + 13'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ro_quant_pack_writer.sv
// Scoreboard bench for ro_quant_pack_writer: expected commands and packed words are queued
// as stimulus is generated and compared when the DUT hands them over.
module tb_ro_quant_pack_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_config_valid, s_config_ready;
    logic [31:0]  s_config_data;
    logic         s_valid, s_ready;
    logic [191:0] s_data;
    logic         cmd_valid, cmd_ready;
    logic [31:0]  cmd_addr;
    logic [15:0]  cmd_len;
    logic         m_valid, m_last, m_ready;
    logic [127:0] m_data;
    logic         done;
    logic [1:0]   status;

    always #5 clk = ~clk;

    ro_quant_pack_writer #(.IN_W(192), .OUT_W(128), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_config_valid(s_config_valid), .s_config_ready(s_config_ready),
        .s_config_data(s_config_data),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .done(done), .status(status)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [47:0]  exp_cmd[$];
    logic [128:0] exp_dat[$];
    logic [23:0]  fixed_lane[8];
    int  m_hold = 0, c_hold = 0, done_cnt = 0;
    bit  rnd_bp = 1'b0;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic finish_tb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    function automatic logic [7:0] quant_ref(input logic [23:0] x, input int sh, input bit relu);
        int v;
        v = int'($signed(x));
        if (sh > 0) v = (v + (1 << (sh - 1))) >>> sh;
        if (relu && v < 0) v = 0;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    // Ready generators: forced-low windows, otherwise optional random backpressure.
    initial begin
        m_ready = 1'b1;
        cmd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready   = (m_hold > 0) ? 1'b0 : (rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
            cmd_ready = (c_hold > 0) ? 1'b0 : (rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1);
            if (m_hold > 0) m_hold--;
            if (c_hold > 0) c_hold--;
        end
    end

    logic         prev_stall = 1'b0, prev_done = 1'b0;
    logic [127:0] prev_data = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check_eq("hold_valid", 160'(m_valid), 160'(1));
                check_eq("hold_data", 160'(m_data), 160'(prev_data));
            end
            if (m_valid && !m_ready) check_eq("stall_s_ready", 160'(s_ready), 160'(0));
            if (cmd_valid) begin
                check_eq("cmd_s_ready", 160'(s_ready), 160'(0));
                check_eq("cmd_m_excl", 160'(m_valid), 160'(0));
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) check_eq("cmd_unexpected", 160'(exp_cmd.size()), 160'(1));
                else check_eq("cmd", 160'({cmd_addr, cmd_len}), 160'(exp_cmd.pop_front()));
            end
            if (m_valid && m_ready) begin
                if (exp_dat.size() == 0) check_eq("data_unexpected", 160'(exp_dat.size()), 160'(1));
                else check_eq("data", 160'({m_last, m_data}), 160'(exp_dat.pop_front()));
            end
            if (done) begin
                done_cnt++;
                check_eq("done_1cyc", 160'(prev_done), 160'(0));
                check_eq("done_status", 160'(status), 160'(3));
            end
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_done  <= done;
        end else begin
            prev_stall <= 1'b0;
            prev_done  <= 1'b0;
        end
    end

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_cfg_ready"}, 160'(s_config_ready), 160'(1));
        check_eq({tag, "_s_ready"},   160'(s_ready),   160'(0));
        check_eq({tag, "_cmd_valid"}, 160'(cmd_valid), 160'(0));
        check_eq({tag, "_m_valid"},   160'(m_valid),   160'(0));
        check_eq({tag, "_m_last"},    160'(m_last),    160'(0));
        check_eq({tag, "_done"},      160'(done),      160'(0));
        check_eq({tag, "_status"},    160'(status),    160'(0));
    endtask

    task automatic send_cfg(input logic [31:0] word);
        int t = 0;
        s_config_valid = 1'b1;
        s_config_data  = word;
        do begin
            @(negedge clk);
            t++;
        end while (!s_config_ready && t < 1000);
        if (t >= 1000) begin
            check_eq("cfg_timeout", 160'(t), 160'(0));
            finish_tb();
        end
        @(posedge clk);
        #1;
        s_config_valid = 1'b0;
    endtask

    task automatic run_job(input int w, input int h, input int tile, input int ch, input int sh,
                           input bit relu, input logic [31:0] base, input int mode,
                           input int stall_at, input int cmd_hold, input int abort_at);
        logic [191:0] beats[$];
        logic [191:0] bt;
        logic [63:0]  px, hold;
        logic [23:0]  lane;
        int segs, rb, d0, t;
        segs = tile * h * (ch / 8);
        rb   = ((w + 1) / 2) * 16;
        hold = '0;
        for (int s = 0; s < segs; s++) begin
            exp_cmd.push_back({base + 32'(s * rb), 16'(rb)});
            for (int p = 0; p < w; p++) begin
                bt = '0;
                px = '0;
                for (int i = 0; i < 8; i++) begin
                    lane = (mode == 0) ? 24'(i + 1) : (mode == 1) ? 24'($urandom) : fixed_lane[i];
                    bt[191 - 24*i -: 24] = lane;
                    px[63 - 8*i -: 8]    = quant_ref(lane, sh, relu);
                end
                beats.push_back(bt);
                if (p % 2 == 1)      exp_dat.push_back({(p == w - 1), hold, px});
                else if (p == w - 1) exp_dat.push_back({1'b1, px, 64'h0});
                else                 hold = px;
            end
        end
        d0 = done_cnt;
        send_cfg({2'b00, relu, 5'(sh), 12'(h), 12'(w)});
        send_cfg({8'h00, 16'(ch), 8'(tile)});
        send_cfg(base);
        s_config_data = '0;
        if (cmd_hold > 0) c_hold = cmd_hold;
        for (int k = 0; k < beats.size(); k++) begin
            if (k == stall_at) m_hold = 10;
            if (k == abort_at) begin
                s_valid = 1'b0;
                rst_n   = 1'b0;
                @(posedge clk);
                #1;
                check_reset_vals("midreset");
                exp_cmd.delete();
                exp_dat.delete();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            s_valid = 1'b1;
            s_data  = beats[k];
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!s_ready && t < 2000);
            if (t >= 2000) begin
                check_eq("beat_timeout", 160'(t), 160'(0));
                finish_tb();
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check_eq("done_pulse", 160'(done_cnt - d0), 160'(1));
        check_eq("sb_cmd_empty", 160'(exp_cmd.size()), 160'(0));
        check_eq("sb_dat_empty", 160'(exp_dat.size()), 160'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        s_config_valid = 1'b0;
        s_config_data  = '0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_job(4, 1, 1, 8, 0, 1'b0, 32'h0000_1000, 0, -1, 0, -1);

        fixed_lane = '{24'h000180, 24'h7FFFFF, 24'h800000, 24'hFFFF80,
                       24'h00007F, 24'h000080, 24'hFF8000, 24'h000000};
        run_job(2, 1, 1, 8, 8, 1'b0, 32'h0000_4000, 2, -1, 0, -1);
        run_job(2, 1, 1, 8, 0, 1'b0, 32'h0000_4000, 2, -1, 0, -1);
        run_job(2, 1, 1, 8, 0, 1'b1, 32'h0000_4000, 2, -1, 0, -1);
        run_job(3, 1, 1, 8, 23, 1'b1, 32'h0000_5000, 1, -1, 0, -1);

        rnd_bp = 1'b1;
        run_job(3, 2, 2, 16, 4, 1'b0, 32'h2000_0000, 1, -1, 0, -1);
        rnd_bp = 1'b0;

        run_job(8, 1, 1, 8, 2, 1'b0, 32'h0000_8000, 1, 3, 0, -1);
        run_job(2, 1, 1, 8, 1, 1'b1, 32'h0000_9000, 1, -1, 5, -1);

        run_job(6, 1, 1, 8, 0, 1'b0, 32'h0000_A000, 1, -1, 0, 4);
        run_job(5, 3, 1, 8, 3, 1'b0, 32'hFFFF_FFF0, 1, -1, 0, -1);

        repeat (5) @(posedge clk);
        finish_tb();
    end

endmodule
